// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
// Holds the response-stage entry type, parameter limits and the address range check.
package instr_mem_pkg;

    localparam int LAT_MAX  = 4;
    localparam int REQS_MAX = 4;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } resp_entry_t;

    // Evaluated at 33 bits so that base + 4*words cannot wrap to a small value.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned words);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + (33'(words) << 2);
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Word-organised instruction store with one preload write port and one read port.
// Read-first on same-address collisions; kept separate so a BRAM or SRAM macro can replace it.
module instr_mem_array #(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    // NOTE: the store and its read register have no reset; a reset would stop this mapping onto BRAM/SRAM.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-memory slave on the req/gnt/rvalid/err fetch bus.
// Grants subject to an in-flight limit and returns in-order responses after a fixed latency.
module instr_mem_responder
    import instr_mem_pkg::*;
#(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LATENCY   = 1,
    parameter int          NUM_REQS  = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         instr_req_i,
    input  logic [31:0]                  instr_addr_i,
    output logic                         instr_gnt_o,
    output logic                         instr_rvalid_o,
    output logic [31:0]                  instr_rdata_o,
    output logic                         instr_err_o,
    input  logic                         gnt_hold_i,
    input  logic                         load_we_i,
    input  logic [$clog2(MEM_WORDS)-1:0] load_addr_i,
    input  logic [31:0]                  load_wdata_i
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(NUM_REQS + 1);

    if (LATENCY < 1 || LATENCY > LAT_MAX || NUM_REQS < 1 || NUM_REQS > REQS_MAX) begin : g_bad_params
        $error("instr_mem_responder: LATENCY or NUM_REQS outside 1..4");
    end

    logic [CW-1:0] outstanding;
    logic          accept;
    logic          retire;
    logic [31:0]   addr_off;
    logic [31:0]   mem_rdata;
    logic          head_valid;
    logic          head_err;
    resp_entry_t   head;
    resp_entry_t   last;
    logic          unused_addr_bits;

    assign instr_gnt_o = instr_req_i & ~gnt_hold_i & (outstanding < CW'(NUM_REQS));
    assign accept      = instr_req_i & instr_gnt_o;
    assign retire      = last.valid;

    assign addr_off         = instr_addr_i - BASE_ADDR;
    assign unused_addr_bits = ^{addr_off[31:AW+2], addr_off[1:0]};

    instr_mem_array #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (load_we_i),
        .waddr (load_addr_i),
        .wdata (load_wdata_i),
        .re    (accept),
        .raddr (addr_off[AW+1:2]),
        .rdata (mem_rdata)
    );

    // Stage 0 control; its data is the array's read register, loaded on the same edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_valid <= 1'b0;
            head_err   <= 1'b0;
        end else begin
            head_valid <= accept;
            head_err   <= ~in_range(instr_addr_i, BASE_ADDR, MEM_WORDS);
        end
    end

    assign head = '{valid: head_valid, err: head_err, rdata: mem_rdata};

    if (LATENCY == 1) begin : g_direct
        assign last = head;
    end else begin : g_pipe
        resp_entry_t tail [1:LATENCY-1];

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int k = 1; k < LATENCY; k++) begin
                    tail[k] <= '0;
                end
            end else begin
                tail[1] <= head;
                for (int k = 2; k < LATENCY; k++) begin
                    tail[k] <= tail[k-1];
                end
            end
        end

        assign last = tail[LATENCY-1];
    end

    // Counter sees the retire only after the edge, so a full pipe frees its slot one cycle late.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outstanding <= '0;
        end else if (accept && !retire) begin
            outstanding <= outstanding + CW'(1);
        end else if (!accept && retire) begin
            outstanding <= outstanding - CW'(1);
        end
    end

    assign instr_rvalid_o = last.valid;
    assign instr_err_o    = last.valid & last.err;
    assign instr_rdata_o  = (last.valid && !last.err) ? last.rdata : 32'h0;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench for instr_mem_responder: two instances (LATENCY 1 and 3) driven by directed and random fetches.
// Expected responses come from an array model of the store plus a list of accept cycles.
module tb_instr_mem_responder;

    localparam int MEM_WORDS = 1024;
    localparam int AW        = 10;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] boot [4] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193};

    task automatic check(input int id, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL dut%0d %s: got %h expected %h (cycle %0d)", id, name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_env
        localparam int          LAT  = (g == 0) ? 1 : 3;
        localparam int          NREQ = 2;
        localparam logic [31:0] BASE = (g == 0) ? 32'h0000_0000 : 32'h0000_2000;

        logic          rstn;
        logic          req;
        logic          gnt;
        logic          rvalid;
        logic          err;
        logic          hold;
        logic          we;
        logic [31:0]   addr;
        logic [31:0]   rdata;
        logic [31:0]   wdata;
        logic [AW-1:0] laddr;
        logic          exp_gnt = 1'b0;
        logic          done_b  = 1'b0;

        logic [31:0]   ref_mem [MEM_WORDS];
        exp_t          sbq [$];
        int            acc_cyc [$];

        instr_mem_responder #(
            .MEM_WORDS (MEM_WORDS),
            .BASE_ADDR (BASE),
            .LATENCY   (LAT),
            .NUM_REQS  (NREQ)
        ) u_dut (
            .clk            (clk),
            .rstn           (rstn),
            .instr_req_i    (req),
            .instr_addr_i   (addr),
            .instr_gnt_o    (gnt),
            .instr_rvalid_o (rvalid),
            .instr_rdata_o  (rdata),
            .instr_err_o    (err),
            .gnt_hold_i     (hold),
            .load_we_i      (we),
            .load_addr_i    (laddr),
            .load_wdata_i   (wdata)
        );

        // One bus cycle: apply inputs, predict the grant, queue the expected response, then apply the preload.
        task automatic drive(input logic r, input logic [31:0] a, input logic h,
                             input logic w, input logic [AW-1:0] la, input logic [31:0] wd);
            exp_t e;
            longint unsigned ua;
            @(posedge clk);
            #1;
            req = r; addr = a; hold = h; we = w; laddr = la; wdata = wd;
            while (acc_cyc.size() > 0 && acc_cyc[0] + LAT < cyc) void'(acc_cyc.pop_front());
            exp_gnt = r && !h && (acc_cyc.size() < NREQ);
            if (exp_gnt) begin
                ua    = 64'(a);
                e.due = cyc + LAT;
                if (ua >= 64'(BASE) && ua < 64'(BASE) + 64'(4 * MEM_WORDS)) begin
                    e.err  = 1'b0;
                    e.data = ref_mem[int'((a - BASE) >> 2)];
                end else begin
                    e.err  = 1'b1;
                    e.data = 32'h0;
                end
                sbq.push_back(e);
                acc_cyc.push_back(cyc);
            end
            if (w) ref_mem[la] = wd;
        endtask

        task automatic fetch(input logic [31:0] a);
            int tries = 0;
            do begin
                drive(1'b1, a, 1'b0, 1'b0, '0, 32'h0);
                tries++;
            end while (!exp_gnt && tries < 8);
        endtask

        task automatic idle(input int n);
            repeat (n) drive(1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0);
        endtask

        always @(negedge clk) begin
            exp_t e;
            check(g, "gnt", {31'b0, gnt}, {31'b0, exp_gnt});
            if (rvalid === 1'b1) begin
                if (sbq.size() == 0) begin
                    check(g, "unexpected rvalid", {31'b0, rvalid}, 32'h0);
                end else begin
                    e = sbq.pop_front();
                    check(g, "resp cycle", 32'(cyc), 32'(e.due));
                    check(g, "resp err", {31'b0, err}, {31'b0, e.err});
                    check(g, "resp rdata", rdata, e.data);
                end
            end else begin
                check(g, "idle rdata", rdata, 32'h0);
                check(g, "idle err", {31'b0, err}, 32'h0);
                if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                    e = sbq.pop_front();
                    check(g, "missing rvalid", {31'b0, rvalid}, 32'h1);
                end
            end
        end

        initial begin
            logic [31:0]   a;
            logic [31:0]   wd;
            logic          r;
            logic          h;
            logic          w;
            logic [AW-1:0] la;
            int            sel;

            rstn = 1'b0; req = 1'b0; addr = '0; hold = 1'b0; we = 1'b0; laddr = '0; wdata = '0;
            repeat (2) @(posedge clk);
            #1 rstn = 1'b1;

            for (int i = 0; i < MEM_WORDS; i++) begin
                if (i < 4) wd = boot[i];
                else       wd = $urandom();
                drive(1'b0, 32'h0, 1'b0, 1'b1, AW'(i), wd);
            end

            // Boot words fetched back to back.
            for (int i = 0; i < 4; i++) fetch(BASE + 32'(4 * i));
            idle(LAT + 2);

            // Continuous requests to exercise the in-flight limit.
            for (int i = 0; i < 12; i++) drive(1'b1, BASE + 32'(4 * i), 1'b0, 1'b0, '0, 32'h0);
            idle(LAT + 2);

            // Range edges, wrap-around address and ignored byte offset.
            fetch(BASE + 32'(4 * MEM_WORDS));
            fetch(BASE + 32'h0000_0FFC);
            fetch(BASE - 32'h4);
            fetch(32'hFFFF_FFFC);
            fetch(BASE + 32'h0000_0013);
            idle(LAT + 2);

            // Grant hold with one response in flight.
            fetch(BASE + 32'h8);
            repeat (3) drive(1'b1, BASE + 32'hC, 1'b1, 1'b0, '0, 32'h0);
            fetch(BASE + 32'hC);
            idle(LAT + 2);

            // Preload and fetch of the same word in one cycle.
            drive(1'b1, BASE + 32'd20, 1'b0, 1'b1, AW'(5), 32'hDEAD_BEEF);
            fetch(BASE + 32'd20);
            idle(LAT + 2);

            // Reset while responses are in flight.
            for (int i = 0; i < 3; i++) drive(1'b1, BASE + 32'(4 * $urandom_range(0, MEM_WORDS - 1)), 1'b0, 1'b0, '0, 32'h0);
            @(posedge clk);
            #1;
            req = 1'b0; hold = 1'b0; we = 1'b0;
            rstn = 1'b0;
            sbq.delete();
            acc_cyc.delete();
            exp_gnt = 1'b0;
            #1;
            check(g, "reset rvalid", {31'b0, rvalid}, 32'h0);
            check(g, "reset err", {31'b0, err}, 32'h0);
            check(g, "reset rdata", rdata, 32'h0);
            repeat (2) @(posedge clk);
            #1 rstn = 1'b1;
            idle(LAT + 3);
            for (int i = 0; i < 6; i++) drive(1'b1, BASE + 32'(4 * i), 1'b0, 1'b0, '0, 32'h0);
            idle(LAT + 2);

            // Random traffic with collisions on low words.
            for (int i = 0; i < 400; i++) begin
                r   = ($urandom_range(0, 3) != 0);
                h   = ($urandom_range(0, 5) == 0);
                w   = ($urandom_range(0, 3) == 0);
                sel = $urandom_range(0, 9);
                la  = (sel < 5) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, MEM_WORDS - 1));
                if (sel == 0)      a = $urandom();
                else if (sel == 1) a = BASE + 32'(4 * MEM_WORDS) + 32'($urandom_range(0, 255));
                else if (sel < 6)  a = BASE + 32'($urandom_range(0, 63));
                else               a = BASE + 32'($urandom_range(0, 4 * MEM_WORDS - 1));
                drive(r, a, h, w, la, $urandom());
            end
            idle(LAT + 3);

            check(g, "scoreboard drained", 32'(sbq.size()), 32'h0);
            done_b = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            if (g_env[0].done_b && g_env[1].done_b) break;
        end
        if (!(g_env[0].done_b && g_env[1].done_b)) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: stimulus did not complete within the cycle budget");
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
